sort_mem_arbiter: RTL and testbench

//  Shares the 32x8 dual-port sort scratchpad between two requesters: host loader/unloader (A) and

---
 rtl/sort_mem_arbiter_pkg.sv | 17 +
 rtl/sort_mem_arbiter_lock_timer.sv | 44 ++++
 rtl/sort_mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_sort_mem_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_mem_arbiter_pkg.sv
// Shared definitions for the sort scratchpad arbiter.
//   DEF_ADDR_W / DEF_DATA_W : default scratchpad geometry (32 x 8)
//   DEF_MAX_LOCK            : default cap on consecutive locked grants while the other side waits
//   owner_e                 : who currently owns the scratchpad (also reused to name the last issuer)
package sort_mem_arbiter_pkg;

  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_MAX_LOCK = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_e;

endpackage

// File: rtl/sort_mem_arbiter_lock_timer.sv
// Saturating counter that measures how long one requester has held a lock while the
// other side was kept waiting.
// Ports:
//   clk_i     : rising-edge clock
//   reset_i   : synchronous active-high reset, clears the count
//   inc_i     : count one more locked cycle (ignored once saturated)
//   clr_i     : restart the count from zero (wins over inc_i)
//   expired_o : count has reached MAX_LOCK-1, so the current locked cycle is the last allowed
module sort_mem_arbiter_lock_timer #(
  parameter int MAX_LOCK = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic expired_o
);

  localparam int CNT_W = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_LOCK - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count saturates at LAST_CNT; the owner FSM breaks the lock on that value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LAST_CNT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/sort_mem_arbiter.sv
// Arbiter sharing the dual-port sort scratchpad between the host loader/unloader (A)
// and the sort engine (B). The owner gets one dual-address access per cycle; holding
// x_lock_i keeps ownership across a read-compare-write, bounded by MAX_LOCK cycles
// while the other side waits.
// Ports:
//   clk_i, reset_i                  : clock, synchronous active-high reset
//   {a,b}_req_i / _lock_i / _we_i   : request, keep-ownership, write-both-ports
//   {a,b}_addr{1,2}_i, _wdata{1,2}_i: per-port address and write data
//   {a,b}_gnt_o                     : registered ownership indication
//   {a,b}_rvalid_o                  : read data valid, one cycle after that side's read
//   rdata{1,2}_o                    : read data shared by both requesters
//   mem_addr{1,2}_o, mem_we_o, mem_wdata{1,2}_o : scratchpad request bus
//   mem_rdata{1,2}_i                : scratchpad read data (1-cycle synchronous read)
//   lock_timeout_o                  : one-cycle pulse when a lock is forcibly broken
module sort_mem_arbiter
  import sort_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_LOCK = DEF_MAX_LOCK
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              a_req_i,
  input  logic              a_lock_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr1_i,
  input  logic [ADDR_W-1:0] a_addr2_i,
  input  logic [DATA_W-1:0] a_wdata1_i,
  input  logic [DATA_W-1:0] a_wdata2_i,
  input  logic              b_req_i,
  input  logic              b_lock_i,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr1_i,
  input  logic [ADDR_W-1:0] b_addr2_i,
  input  logic [DATA_W-1:0] b_wdata1_i,
  input  logic [DATA_W-1:0] b_wdata2_i,
  output logic              a_gnt_o,
  output logic              b_gnt_o,
  output logic              a_rvalid_o,
  output logic              b_rvalid_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o,
  output logic [ADDR_W-1:0] mem_addr1_o,
  output logic [ADDR_W-1:0] mem_addr2_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata1_o,
  output logic [DATA_W-1:0] mem_wdata2_o,
  input  logic [DATA_W-1:0] mem_rdata1_i,
  input  logic [DATA_W-1:0] mem_rdata2_i,
  output logic              lock_timeout_o
);

  owner_e owner_q, owner_d;
  owner_e last_q, last_d;
  logic   a_issue, b_issue;
  logic   lock_held, other_req;
  logic   lock_inc, lock_clr, lock_expired;
  logic   timeout_q, timeout_d;
  logic   a_rvalid_q, b_rvalid_q;

  assign a_issue = (owner_q == OWN_A) && a_req_i;
  assign b_issue = (owner_q == OWN_B) && b_req_i;

  // Request mux: the owner's bus drives the memory; no owner parks the bus at zero.
  // An owner that is not requesting keeps its addresses on the bus but never writes.
  always_comb begin
    mem_addr1_o  = '0;
    mem_addr2_o  = '0;
    mem_wdata1_o = '0;
    mem_wdata2_o = '0;
    mem_we_o     = 1'b0;
    unique case (owner_q)
      OWN_A: begin
        mem_addr1_o  = a_addr1_i;
        mem_addr2_o  = a_addr2_i;
        mem_wdata1_o = a_wdata1_i;
        mem_wdata2_o = a_wdata2_i;
        mem_we_o     = a_req_i & a_we_i;
      end
      OWN_B: begin
        mem_addr1_o  = b_addr1_i;
        mem_addr2_o  = b_addr2_i;
        mem_wdata1_o = b_wdata1_i;
        mem_wdata2_o = b_wdata2_i;
        mem_we_o     = b_req_i & b_we_i;
      end
      default: ;
    endcase
  end

  // Next owner. A held lock keeps ownership until the timer says the waiting side has
  // been starved long enough. Otherwise round-robin against the most recent issuer,
  // including an access issued in this very cycle, so back-to-back contention alternates.
  always_comb begin
    last_d = last_q;
    if (a_issue) begin
      last_d = OWN_A;
    end else if (b_issue) begin
      last_d = OWN_B;
    end

    other_req = 1'b0;
    lock_held = 1'b0;
    unique case (owner_q)
      OWN_A: begin
        other_req = b_req_i;
        lock_held = a_req_i & a_lock_i;
      end
      OWN_B: begin
        other_req = a_req_i;
        lock_held = b_req_i & b_lock_i;
      end
      default: ;
    endcase

    owner_d   = OWN_NONE;
    timeout_d = 1'b0;
    if (lock_held && other_req && lock_expired) begin
      timeout_d = 1'b1;
      if (owner_q == OWN_A) begin
        owner_d = OWN_B;
      end else begin
        owner_d = OWN_A;
      end
    end else if (lock_held) begin
      owner_d = owner_q;
    end else if (a_req_i && b_req_i) begin
      if (last_d == OWN_A) begin
        owner_d = OWN_B;
      end else begin
        owner_d = OWN_A;
      end
    end else if (a_req_i) begin
      owner_d = OWN_A;
    end else if (b_req_i) begin
      owner_d = OWN_B;
    end

    // Only starvation of a waiting requester is counted.
    lock_inc = lock_held && other_req;
    lock_clr = (owner_d != owner_q) || !other_req;
  end

  sort_mem_arbiter_lock_timer #(
    .MAX_LOCK(MAX_LOCK)
  ) u_lock_timer (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .inc_i    (lock_inc),
    .clr_i    (lock_clr),
    .expired_o(lock_expired)
  );

  // Owner FSM plus rvalid steering. rvalid follows the side that issued the read,
  // even if ownership moves on at the same edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      owner_q    <= OWN_NONE;
      last_q     <= OWN_B;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      last_q     <= last_d;
      a_rvalid_q <= a_issue & ~a_we_i;
      b_rvalid_q <= b_issue & ~b_we_i;
      timeout_q  <= timeout_d;
    end
  end

  assign a_gnt_o        = (owner_q == OWN_A);
  assign b_gnt_o        = (owner_q == OWN_B);
  assign a_rvalid_o     = a_rvalid_q;
  assign b_rvalid_o     = b_rvalid_q;
  assign lock_timeout_o = timeout_q;

  // The scratchpad already registers its read data, so it is forwarded as-is.
  assign rdata1_o = mem_rdata1_i;
  assign rdata2_o = mem_rdata2_i;

endmodule

// File: tb/tb_sort_mem_arbiter.sv
// Bench for sort_mem_arbiter: a 32x8 scratchpad model, a per-cycle behavioural reference
// of the arbitration rules, directed scenarios with literal expectations, a small
// load/sort/unload flow and randomized contention.
module tb_sort_mem_arbiter;

  localparam int MAX_LOCK = 16;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       a_req_i, a_lock_i, a_we_i;
  logic [4:0] a_addr1_i, a_addr2_i;
  logic [7:0] a_wdata1_i, a_wdata2_i;
  logic       b_req_i, b_lock_i, b_we_i;
  logic [4:0] b_addr1_i, b_addr2_i;
  logic [7:0] b_wdata1_i, b_wdata2_i;
  logic       a_gnt_o, b_gnt_o, a_rvalid_o, b_rvalid_o;
  logic [7:0] rdata1_o, rdata2_o;
  logic [4:0] mem_addr1_o, mem_addr2_o;
  logic       mem_we_o;
  logic [7:0] mem_wdata1_o, mem_wdata2_o;
  logic [7:0] mem_rdata1_i, mem_rdata2_i;
  logic       lock_timeout_o;

  int checksTotal  = 0;
  int checksPassed = 0;

  always #5 clk_i = ~clk_i;

  sort_mem_arbiter dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .a_req_i(a_req_i), .a_lock_i(a_lock_i), .a_we_i(a_we_i),
    .a_addr1_i(a_addr1_i), .a_addr2_i(a_addr2_i),
    .a_wdata1_i(a_wdata1_i), .a_wdata2_i(a_wdata2_i),
    .b_req_i(b_req_i), .b_lock_i(b_lock_i), .b_we_i(b_we_i),
    .b_addr1_i(b_addr1_i), .b_addr2_i(b_addr2_i),
    .b_wdata1_i(b_wdata1_i), .b_wdata2_i(b_wdata2_i),
    .a_gnt_o(a_gnt_o), .b_gnt_o(b_gnt_o),
    .a_rvalid_o(a_rvalid_o), .b_rvalid_o(b_rvalid_o),
    .rdata1_o(rdata1_o), .rdata2_o(rdata2_o),
    .mem_addr1_o(mem_addr1_o), .mem_addr2_o(mem_addr2_o),
    .mem_we_o(mem_we_o),
    .mem_wdata1_o(mem_wdata1_o), .mem_wdata2_o(mem_wdata2_o),
    .mem_rdata1_i(mem_rdata1_i), .mem_rdata2_i(mem_rdata2_i),
    .lock_timeout_o(lock_timeout_o)
  );

  // Scratchpad: synchronous read, both ports written together, port 2 wins on a shared address.
  logic [7:0] memArray [32] = '{default: 8'h00};
  always @(posedge clk_i) begin
    if (mem_we_o) begin
      memArray[mem_addr1_o] <= mem_wdata1_o;
      memArray[mem_addr2_o] <= mem_wdata2_o;
    end else begin
      mem_rdata1_i <= memArray[mem_addr1_o];
      mem_rdata2_i <= memArray[mem_addr2_o];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: owner 0=none 1=A 2=B, lastSide = who issued most recently,
  // lockRun = consecutive cycles the owner kept a lock while the other side asked.
  bit         modelOn = 1'b0;
  int         mOwner = 0, mLast = 2, mRun = 0;
  bit         mRvA = 1'b0, mRvB = 1'b0, mTimeout = 1'b0;
  logic [7:0] mRd1, mRd2;
  logic [7:0] refMem [32] = '{default: 8'h00};
  int         issuer;
  bit         issWrite, reqOwn, lockOwn, reqOther;
  logic [4:0] eAddr1, eAddr2;
  logic [7:0] eW1, eW2;
  int         timeoutPulses = 0;

  always @(negedge clk_i) begin
    if (lock_timeout_o === 1'b1) timeoutPulses++;
  end

  // Single compare process: check this cycle's outputs, then advance the model one edge.
  always @(negedge clk_i) begin
    if (modelOn) begin
      issuer = 0;
      if (mOwner == 1 && a_req_i) issuer = 1;
      if (mOwner == 2 && b_req_i) issuer = 2;
      issWrite = (issuer == 1 && a_we_i) || (issuer == 2 && b_we_i);
      eAddr1 = 5'd0; eAddr2 = 5'd0; eW1 = 8'd0; eW2 = 8'd0;
      if (mOwner == 1) begin
        eAddr1 = a_addr1_i; eAddr2 = a_addr2_i; eW1 = a_wdata1_i; eW2 = a_wdata2_i;
      end else if (mOwner == 2) begin
        eAddr1 = b_addr1_i; eAddr2 = b_addr2_i; eW1 = b_wdata1_i; eW2 = b_wdata2_i;
      end

      checkOutput("a_gnt", a_gnt_o, mOwner == 1);
      checkOutput("b_gnt", b_gnt_o, mOwner == 2);
      checkOutput("mem_we", mem_we_o, issWrite);
      checkOutput("mem_addr1", mem_addr1_o, eAddr1);
      checkOutput("mem_addr2", mem_addr2_o, eAddr2);
      if (issWrite) begin
        checkOutput("mem_wdata1", mem_wdata1_o, eW1);
        checkOutput("mem_wdata2", mem_wdata2_o, eW2);
      end
      checkOutput("a_rvalid", a_rvalid_o, mRvA);
      checkOutput("b_rvalid", b_rvalid_o, mRvB);
      if (mRvA || mRvB) begin
        checkOutput("rdata1", rdata1_o, mRd1);
        checkOutput("rdata2", rdata2_o, mRd2);
      end
      checkOutput("lock_timeout", lock_timeout_o, mTimeout);

      mRvA = (issuer == 1) && !issWrite;
      mRvB = (issuer == 2) && !issWrite;
      if (issuer != 0 && !issWrite) begin
        mRd1 = refMem[eAddr1];
        mRd2 = refMem[eAddr2];
      end
      if (issWrite) begin
        refMem[eAddr1] = eW1;
        refMem[eAddr2] = eW2;
      end
      if (issuer != 0) mLast = issuer;

      reqOwn   = (mOwner == 1) ? a_req_i  : (mOwner == 2) ? b_req_i  : 1'b0;
      lockOwn  = (mOwner == 1) ? a_lock_i : (mOwner == 2) ? b_lock_i : 1'b0;
      reqOther = (mOwner == 1) ? b_req_i  : (mOwner == 2) ? a_req_i  : 1'b0;
      mTimeout = 1'b0;
      if (reqOwn && lockOwn && reqOther) begin
        mRun++;
        if (mRun >= MAX_LOCK) begin
          mOwner   = 3 - mOwner;
          mRun     = 0;
          mTimeout = 1'b1;
        end
      end else if (reqOwn && lockOwn) begin
        mRun = 0;
      end else begin
        mRun = 0;
        if (a_req_i && b_req_i) mOwner = (mLast == 1) ? 2 : 1;
        else if (a_req_i)       mOwner = 1;
        else if (b_req_i)       mOwner = 2;
        else                    mOwner = 0;
      end

      if (reset_i) begin
        mOwner = 0; mLast = 2; mRun = 0;
        mRvA = 1'b0; mRvB = 1'b0; mTimeout = 1'b0;
      end
    end
  end

  task automatic setIdle();
    a_req_i = 0; a_lock_i = 0; a_we_i = 0;
    b_req_i = 0; b_lock_i = 0; b_we_i = 0;
  endtask

  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  // One access for side A (sideB=0) or B: hold the request until granted, let it issue,
  // and return one cycle later with the request still asserted.
  task automatic applyStimulus(input bit sideB, input bit we, input bit lk,
                               input logic [4:0] ad1, input logic [4:0] ad2,
                               input logic [7:0] d1, input logic [7:0] d2);
    int waitCycles = 0;
    if (!sideB) begin
      a_req_i = 1; a_we_i = we; a_lock_i = lk;
      a_addr1_i = ad1; a_addr2_i = ad2; a_wdata1_i = d1; a_wdata2_i = d2;
    end else begin
      b_req_i = 1; b_we_i = we; b_lock_i = lk;
      b_addr1_i = ad1; b_addr2_i = ad2; b_wdata1_i = d1; b_wdata2_i = d2;
    end
    while (!(sideB ? b_gnt_o : a_gnt_o) && waitCycles < 100) begin
      nextCycle();
      waitCycles++;
    end
    checkOutput("grant_seen", sideB ? b_gnt_o : a_gnt_o, 1);
    nextCycle();
  endtask

  task automatic pulseReset();
    setIdle();
    reset_i = 1;
    nextCycle();
    reset_i = 0;
  endtask

  logic [7:0] listIn  [5];
  logic [7:0] listOut [5];
  logic [7:0] sortedRef [5];
  logic [7:0] r1, r2, sw1, sw2;
  int         n, pulsesBefore;

  initial begin
    listIn    = '{8'h42, 8'h07, 8'h99, 8'h15, 8'h63};
    sortedRef = '{8'h07, 8'h15, 8'h42, 8'h63, 8'h99};
    a_addr1_i = 0; a_addr2_i = 0; a_wdata1_i = 0; a_wdata2_i = 0;
    b_addr1_i = 0; b_addr2_i = 0; b_wdata1_i = 0; b_wdata2_i = 0;
    setIdle();
    reset_i = 1;
    repeat (2) @(posedge clk_i);
    #1;
    modelOn = 1'b1;
    checkOutput("rst_a_gnt", a_gnt_o, 0);
    checkOutput("rst_b_gnt", b_gnt_o, 0);
    checkOutput("rst_mem_we", mem_we_o, 0);
    checkOutput("rst_rvalid", {a_rvalid_o, b_rvalid_o}, 0);
    checkOutput("rst_timeout", lock_timeout_o, 0);

    // Write 11/22 to 3/4, read it back.
    reset_i = 0;
    a_req_i = 1; a_we_i = 1; a_addr1_i = 3; a_addr2_i = 4; a_wdata1_i = 8'h11; a_wdata2_i = 8'h22;
    nextCycle();
    checkOutput("t1_a_gnt", a_gnt_o, 1);
    checkOutput("t1_mem_we", mem_we_o, 1);
    checkOutput("t1_addr1", mem_addr1_o, 3);
    checkOutput("t1_addr2", mem_addr2_o, 4);
    nextCycle();
    a_we_i = 0;
    nextCycle();
    checkOutput("t1_a_rvalid", a_rvalid_o, 1);
    checkOutput("t1_rdata1", rdata1_o, 8'h11);
    checkOutput("t1_rdata2", rdata2_o, 8'h22);
    setIdle();
    nextCycle();

    // Both requesting without lock alternates A,B,A,B starting with A.
    pulseReset();
    a_req_i = 1; a_addr1_i = 1; a_addr2_i = 2;
    b_req_i = 1; b_addr1_i = 3; b_addr2_i = 4;
    for (int k = 1; k <= 4; k++) begin
      nextCycle();
      checkOutput("t2_a_gnt", a_gnt_o, (k % 2) == 1);
      checkOutput("t2_b_gnt", b_gnt_o, (k % 2) == 0);
      checkOutput("t2_b_rvalid", b_rvalid_o, k == 3);
      checkOutput("t2_a_rvalid", a_rvalid_o, (k % 2) == 0);
    end
    setIdle();
    nextCycle();

    // B keeps a 4-cycle locked read-swap-write on 7/8 while A waits.
    pulseReset();
    b_req_i = 1; b_lock_i = 1; b_we_i = 0; b_addr1_i = 7; b_addr2_i = 8;
    nextCycle();
    a_req_i = 1; a_we_i = 0; a_addr1_i = 0; a_addr2_i = 0;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      checkOutput("t3_a_blocked", a_gnt_o, 0);
      checkOutput("t3_b_owner", b_gnt_o, 1);
      if (cyc == 2) begin sw1 = rdata2_o; sw2 = rdata1_o; end
      if (cyc == 4) begin b_we_i = 1; b_lock_i = 0; b_wdata1_i = sw1; b_wdata2_i = sw2; end
      nextCycle();
    end
    checkOutput("t3_a_after", a_gnt_o, 1);
    setIdle();
    nextCycle();

    // B holds the lock indefinitely: 16 B cycles, then A with a single timeout pulse.
    pulseReset();
    pulsesBefore = timeoutPulses;
    b_req_i = 1; b_lock_i = 1; b_we_i = 0; b_addr1_i = 0; b_addr2_i = 1;
    nextCycle();
    a_req_i = 1; a_lock_i = 0; a_we_i = 0;
    n = 0;
    while (!a_gnt_o && n < 40) begin
      if (b_gnt_o) n++;
      nextCycle();
    end
    checkOutput("t4_b_cycles", n, 16);
    checkOutput("t4_a_gnt", a_gnt_o, 1);
    checkOutput("t4_timeout", lock_timeout_o, 1);
    nextCycle();
    checkOutput("t4_timeout_end", lock_timeout_o, 0);
    setIdle();
    repeat (3) nextCycle();
    checkOutput("t4_pulses", timeoutPulses - pulsesBefore, 1);

    // Reset while B is locked with a read going out.
    pulseReset();
    b_req_i = 1; b_lock_i = 1; b_we_i = 0; b_addr1_i = 7; b_addr2_i = 8;
    nextCycle();
    reset_i = 1;
    nextCycle();
    checkOutput("t5_a_gnt", a_gnt_o, 0);
    checkOutput("t5_b_gnt", b_gnt_o, 0);
    checkOutput("t5_b_rvalid", b_rvalid_o, 0);
    reset_i = 0;
    setIdle();
    nextCycle();

    // Load via A, bubble sort via B with locked read/write pairs, unload via A.
    applyStimulus(0, 1, 0, 5'd0, 5'd1, listIn[0], listIn[1]);
    applyStimulus(0, 1, 0, 5'd2, 5'd3, listIn[2], listIn[3]);
    applyStimulus(0, 1, 0, 5'd4, 5'd4, listIn[4], listIn[4]);
    setIdle();
    for (int pass = 0; pass < 4; pass++) begin
      for (int i = 0; i < 4 - pass; i++) begin
        applyStimulus(1, 0, 1, 5'(i), 5'(i + 1), 8'd0, 8'd0);
        r1 = rdata1_o;
        r2 = rdata2_o;
        if (r1 > r2) applyStimulus(1, 1, 0, 5'(i), 5'(i + 1), r2, r1);
        else         applyStimulus(1, 1, 0, 5'(i), 5'(i + 1), r1, r2);
      end
    end
    setIdle();
    applyStimulus(0, 0, 0, 5'd0, 5'd1, 8'd0, 8'd0);
    listOut[0] = rdata1_o; listOut[1] = rdata2_o;
    applyStimulus(0, 0, 0, 5'd2, 5'd3, 8'd0, 8'd0);
    listOut[2] = rdata1_o; listOut[3] = rdata2_o;
    applyStimulus(0, 0, 0, 5'd4, 5'd4, 8'd0, 8'd0);
    listOut[4] = rdata1_o;
    setIdle();
    for (int i = 0; i < 5; i++) checkOutput("t6_sorted", listOut[i], sortedRef[i]);
    nextCycle();

    // Random contention; second half keeps B locked to exercise lock breaking.
    for (int c = 0; c < 600; c++) begin
      reset_i    = ($urandom_range(0, 99) == 0);
      a_req_i    = ($urandom_range(0, 7) != 0);
      a_lock_i   = ($urandom_range(0, 3) != 0);
      a_we_i     = $urandom_range(0, 1) == 1;
      a_addr1_i  = 5'($urandom_range(0, 31));
      a_addr2_i  = 5'($urandom_range(0, 31));
      a_wdata1_i = 8'($urandom_range(0, 255));
      a_wdata2_i = 8'($urandom_range(0, 255));
      b_req_i    = (c >= 300) ? 1'b1 : ($urandom_range(0, 7) != 0);
      b_lock_i   = (c >= 300) ? 1'b1 : ($urandom_range(0, 3) != 0);
      b_we_i     = $urandom_range(0, 1) == 1;
      b_addr1_i  = 5'($urandom_range(0, 31));
      b_addr2_i  = 5'($urandom_range(0, 31));
      b_wdata1_i = 8'($urandom_range(0, 255));
      b_wdata2_i = 8'($urandom_range(0, 255));
      nextCycle();
    end
    reset_i = 0;
    setIdle();
    repeat (3) nextCycle();

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
